// File: rtl/pio_pkg.sv
// Shared types and helpers for the PIO fetch sequencer.
package pio_pkg;

  localparam int unsigned PIO_ADDR_W = 4;
  localparam int unsigned PIO_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, STALL} fetch_state_t;

  // Sequential successor of pc: wrap only on exactly reaching wrap_top, else +1 mod 2**addr_w.
  function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                          input logic [31:0] wrap_top,
                                          input logic [31:0] wrap_bottom,
                                          input int unsigned addr_w);
    logic [31:0] mask;
    mask = (32'd1 << addr_w) - 32'd1;
    if (pc == wrap_top) return wrap_bottom;
    return (pc + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/pio_fetch_sequencer_if.sv
// Host program-load handshake into the instruction register file.
interface pio_fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  modport master (output load_valid, load_addr, load_data, input load_ready);
  modport slave  (input load_valid, load_addr, load_data, output load_ready);
endinterface

// File: rtl/pio_pc_next.sv
// Next fetch address: restart over jump over wrap/increment.
module pio_pc_next
  import pio_pkg::*;
#(
  parameter int unsigned ADDR_W = PIO_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] wrap_top_i,
  input  logic [ADDR_W-1:0] wrap_bottom_i,
  input  logic              restart_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic              jmp_valid_i,
  input  logic [ADDR_W-1:0] jmp_addr_i,
  output logic [ADDR_W-1:0] pc_next_o
);

  logic [31:0] seq_pc;
  logic        unused_seq_hi;

  assign seq_pc        = next_pc(32'(pc_i), 32'(wrap_top_i), 32'(wrap_bottom_i), ADDR_W);
  assign unused_seq_hi = ^seq_pc[31:ADDR_W];

  // Priority mux of the candidate addresses.
  always_comb begin
    pc_next_o = seq_pc[ADDR_W-1:0];
    if (restart_i) begin
      pc_next_o = start_addr_i;
    end else if (jmp_valid_i) begin
      pc_next_o = jmp_addr_i;
    end
  end

endmodule

// File: rtl/pio_fetch_sequencer.sv
// PIO program counter / fetch controller with host load port.
// Optional breakpoint support when PIO_FETCH_BREAKPOINT_EN is defined.
module pio_fetch_sequencer
  import pio_pkg::*;
#(
  parameter int unsigned ADDR_W = PIO_ADDR_W,
  parameter int unsigned DATA_W = PIO_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  restart,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     wrap_bottom,
  input  logic [ADDR_W-1:0]     wrap_top,
  input  logic                  stall,
  input  logic                  jmp_valid,
  input  logic [ADDR_W-1:0]     jmp_addr,
  output logic [DATA_W-1:0]     instr_out,
  output logic [ADDR_W-1:0]     instr_pc,
  output logic                  instr_valid,
  output logic [ADDR_W-1:0]     pc,
  output logic [ADDR_W-1:0]     rf_read_addr,
  input  logic [DATA_W-1:0]     rf_data_out,
  pio_fetch_sequencer_if.slave  load_if,
  output logic                  rf_write_en,
  output logic [ADDR_W-1:0]     rf_write_addr,
  output logic [DATA_W-1:0]     rf_data_in
`ifdef PIO_FETCH_BREAKPOINT_EN
  ,
  input  logic                  bp_en,
  input  logic [ADDR_W-1:0]     bp_addr,
  output logic                  bp_hit
`endif
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_next;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              valid_q, valid_d;
  logic              bp_block;
`ifdef PIO_FETCH_BREAKPOINT_EN
  logic              bp_hit_q, bp_hit_d;
  assign bp_block = bp_hit_q;
  assign bp_hit   = bp_hit_q;
`else
  assign bp_block = 1'b0;
`endif

  pio_pc_next #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc_i          (pc_q),
    .wrap_top_i    (wrap_top),
    .wrap_bottom_i (wrap_bottom),
    .restart_i     (restart),
    .start_addr_i  (start_addr),
    .jmp_valid_i   (jmp_valid),
    .jmp_addr_i    (jmp_addr),
    .pc_next_o     (pc_next)
  );

  // Host writes are only granted while parked; otherwise held off at the source.
  assign load_if.load_ready = (state_q == IDLE);
  assign rf_write_en        = load_if.load_valid & load_if.load_ready;
  assign rf_write_addr      = load_if.load_addr;
  assign rf_data_in         = load_if.load_data;

  assign rf_read_addr = pc_q;
  assign pc           = pc_q;
  assign instr_out    = instr_q;
  assign instr_pc     = ipc_q;
  assign instr_valid  = valid_q;

  // FSM next state, pc update and fetch register capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = 1'b0;
`ifdef PIO_FETCH_BREAKPOINT_EN
    bp_hit_d = bp_hit_q;
`endif
    if (restart) begin
      // Restart retargets pc without moving the FSM.
      pc_d = pc_next;
`ifdef PIO_FETCH_BREAKPOINT_EN
      bp_hit_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable && !bp_block) state_d = RUN;
        end
        RUN: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (stall) begin
            state_d = STALL;
          end else begin
            pc_d = pc_next;
            // A jump discards the word fetched this cycle.
            if (!jmp_valid) begin
              instr_d = rf_data_out;
              ipc_d   = pc_q;
              valid_d = 1'b1;
`ifdef PIO_FETCH_BREAKPOINT_EN
              if (bp_en && (pc_q == bp_addr)) begin
                state_d  = IDLE;
                bp_hit_d = 1'b1;
              end
`endif
            end
          end
        end
        STALL: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (!stall) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef PIO_FETCH_BREAKPOINT_EN
    if (!enable) bp_hit_d = 1'b0;
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
`ifdef PIO_FETCH_BREAKPOINT_EN
      bp_hit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
`ifdef PIO_FETCH_BREAKPOINT_EN
      bp_hit_q <= bp_hit_d;
`endif
    end
  end

endmodule

// File: tb/tb_pio_fetch_sequencer.sv
// Self-checking bench for pio_fetch_sequencer with a behavioural reference model.
module tb_pio_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, restart, stall, jmp_valid;
  logic [3:0] start_addr, wrap_bottom, wrap_top, jmp_addr;
  logic [7:0] instr_out;
  logic [3:0] instr_pc, pc, rf_read_addr, rf_write_addr;
  logic       instr_valid, rf_write_en;
  logic [7:0] rf_data_out, rf_data_in;
`ifdef PIO_FETCH_BREAKPOINT_EN
  logic       bp_en, bp_hit;
  logic [3:0] bp_addr;
`endif

  always #5 clk = ~clk;

  pio_fetch_sequencer_if #(.ADDR_W(4), .DATA_W(8)) load_if ();

  pio_fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .restart       (restart),
    .start_addr    (start_addr),
    .wrap_bottom   (wrap_bottom),
    .wrap_top      (wrap_top),
    .stall         (stall),
    .jmp_valid     (jmp_valid),
    .jmp_addr      (jmp_addr),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .rf_read_addr  (rf_read_addr),
    .rf_data_out   (rf_data_out),
    .load_if       (load_if.slave),
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_data_in    (rf_data_in)
`ifdef PIO_FETCH_BREAKPOINT_EN
    ,
    .bp_en         (bp_en),
    .bp_addr       (bp_addr),
    .bp_hit        (bp_hit)
`endif
  );

  // Instruction register file: registered write, combinational read.
  logic [7:0] rf_mem [16];
  always @(posedge clk) if (rf_write_en) rf_mem[rf_write_addr] <= rf_data_in;
  assign rf_data_out = rf_mem[rf_read_addr];

  // Reference model state.
  bit         m_active, m_stalled, m_valid, m_bp;
  logic [3:0] m_pc, m_ipc;
  logic [7:0] m_out;
  logic [7:0] ref_mem [16];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_stalled = 0; m_valid = 0; m_bp = 0;
    m_pc = '0; m_ipc = '0; m_out = '0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    bit         n_active, n_stalled, n_valid, n_bp, grant;
    logic [3:0] n_pc, n_ipc;
    logic [7:0] n_out;
    #1;
    grant = load_if.load_valid && !m_active;
    chk("load_ready", 32'(load_if.load_ready), 32'(!m_active));
    chk("rf_write_en", 32'(rf_write_en), 32'(grant));
    chk("rf_read_addr", 32'(rf_read_addr), 32'(m_pc));
    if (grant) begin
      chk("rf_write_addr", 32'(rf_write_addr), 32'(load_if.load_addr));
      chk("rf_data_in", 32'(rf_data_in), 32'(load_if.load_data));
    end
    n_active = m_active; n_stalled = m_stalled; n_valid = 0; n_bp = m_bp;
    n_pc = m_pc; n_ipc = m_ipc; n_out = m_out;
    if (restart) begin
      n_pc = start_addr;
      n_bp = 0;
    end else if (!m_active) begin
      if (enable && !m_bp) begin n_active = 1; n_stalled = 0; end
    end else if (!enable) begin
      n_active = 0;
    end else if (m_stalled) begin
      if (!stall) n_stalled = 0;
    end else if (stall) begin
      n_stalled = 1;
    end else if (jmp_valid) begin
      n_pc = jmp_addr;
    end else begin
      n_valid = 1;
      n_out   = ref_mem[m_pc];
      n_ipc   = m_pc;
      n_pc    = (m_pc == wrap_top) ? wrap_bottom : m_pc + 4'd1;
`ifdef PIO_FETCH_BREAKPOINT_EN
      if (bp_en && m_pc == bp_addr) begin n_active = 0; n_bp = 1; end
`endif
    end
    if (!enable) n_bp = 0;
    if (grant) ref_mem[load_if.load_addr] = load_if.load_data;
    @(posedge clk);
    #1;
    m_active = n_active; m_stalled = n_stalled; m_valid = n_valid; m_bp = n_bp;
    m_pc = n_pc; m_ipc = n_ipc; m_out = n_out;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    if (m_valid) begin
      chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
      chk("instr_out", 32'(instr_out), 32'(m_out));
    end
`ifdef PIO_FETCH_BREAKPOINT_EN
    chk("bp_hit", 32'(bp_hit), 32'(m_bp));
`endif
  endtask

  task automatic run_until_pc(input logic [3:0] target);
    int n = 0;
    while (m_pc != target && n < 40) begin
      tick();
      n++;
    end
    chk("reach_pc", 32'(pc), 32'(target));
  endtask

  logic [3:0] exp_seq [6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd2, 4'd3};

  initial begin
    rst = 1'b1; enable = 0; restart = 0; stall = 0; jmp_valid = 0;
    start_addr = 0; wrap_bottom = 0; wrap_top = 4'hF; jmp_addr = 0;
    load_if.load_valid = 0; load_if.load_addr = 0; load_if.load_data = 0;
`ifdef PIO_FETCH_BREAKPOINT_EN
    bp_en = 0; bp_addr = 0;
`endif
    model_reset();
    #12;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_out", 32'(instr_out), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_load_ready", 32'(load_if.load_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Program load while parked; address 6 gets 0xA5.
    for (int a = 0; a < 16; a++) begin
      load_if.load_valid = 1;
      load_if.load_addr  = 4'(a);
      load_if.load_data  = (a == 6) ? 8'hA5 : 8'($urandom);
      tick();
    end
    load_if.load_valid = 0;

    // Wrap window 2..5 from a restart at 2.
    wrap_bottom = 4'd2; wrap_top = 4'd5; start_addr = 4'd2;
    restart = 1; tick(); restart = 0;
    enable = 1; tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("wrap_seq_pc", 32'(instr_pc), 32'(exp_seq[i]));
      chk("wrap_seq_valid", 32'(instr_valid), 32'd1);
    end

    // Jump from 4 to 9 with a one-cycle bubble.
    run_until_pc(4'd4);
    jmp_valid = 1; jmp_addr = 4'd9; tick();
    chk("jmp_bubble", 32'(instr_valid), 32'd0);
    chk("jmp_pc", 32'(pc), 32'd9);
    jmp_valid = 0; tick();
    chk("jmp_target_issued", 32'(instr_pc), 32'd9);

    // Stall for three cycles at 3; a jump request during stall is ignored.
    run_until_pc(4'd3);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      jmp_valid = (i == 1); jmp_addr = 4'd12;
      tick();
      chk("stall_pc", 32'(pc), 32'd3);
      chk("stall_valid", 32'(instr_valid), 32'd0);
    end
    stall = 0; jmp_valid = 0;
    tick(); tick();
    chk("stall_resume_pc", 32'(instr_pc), 32'd3);

    // Load during RUN is held off until enable drops.
    load_if.load_valid = 1; load_if.load_addr = 4'd6; load_if.load_data = 8'h5A;
    tick(); tick();
    enable = 0; tick();
    tick();
    load_if.load_valid = 0;

    // Restart beats a simultaneous jump.
    enable = 1; tick(); tick(); tick();
    restart = 1; jmp_valid = 1; start_addr = 4'd1; jmp_addr = 4'd8;
    tick();
    chk("restart_over_jmp", 32'(pc), 32'd1);
    restart = 0; jmp_valid = 0;
    tick();

`ifdef PIO_FETCH_BREAKPOINT_EN
    wrap_top = 4'hF; bp_en = 1; bp_addr = 4'd3;
    for (int n = 0; n < 40 && !m_bp; n++) tick();
    chk("bp_instr_pc", 32'(instr_pc), 32'd3);
    chk("bp_hit_set", 32'(bp_hit), 32'd1);
    tick(); tick();
    chk("bp_parked", 32'(load_if.load_ready), 32'd1);
    bp_en = 0; enable = 0; tick();
    enable = 1; tick();
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      enable    = ($urandom_range(0, 15) != 0);
      stall     = ($urandom_range(0, 3) == 0);
      jmp_valid = ($urandom_range(0, 4) == 0);
      jmp_addr  = 4'($urandom);
      load_if.load_valid = ($urandom_range(0, 2) == 0);
      load_if.load_addr  = 4'($urandom);
      load_if.load_data  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        wrap_top = 4'($urandom); wrap_bottom = 4'($urandom);
      end
      restart = 0;
      if (enable && !stall && m_active && !m_stalled && $urandom_range(0, 9) == 0) begin
        restart = 1; start_addr = 4'($urandom);
      end
`ifdef PIO_FETCH_BREAKPOINT_EN
      bp_en = ($urandom_range(0, 5) == 0); bp_addr = 4'($urandom);
`endif
      tick();
    end

    // Asynchronous reset in the middle of a run at pc 7.
    restart = 0; stall = 0; jmp_valid = 0; load_if.load_valid = 0; wrap_top = 4'hF;
`ifdef PIO_FETCH_BREAKPOINT_EN
    bp_en = 0;
`endif
    enable = 0; tick();
    enable = 1; tick();
    run_until_pc(4'd7);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_valid", 32'(instr_valid), 32'd0);
    chk("async_rst_pc", 32'(pc), 32'd0);
    chk("async_rst_ready", 32'(load_if.load_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_fetch_sequencer.md
Name: pio_fetch_sequencer

Overview:
Program-counter and fetch controller for the 16-entry instruction register file of a PIO state machine.
- Read side: drives the regfile read address and registers the fetched instruction for the executor, with PIO-style wrap, jumps, stall and restart.
- Write side: owns the regfile write port and grants host program loads only while the sequencer is idle.

Parameters:
ADDR_W, 4, instruction address width (regfile depth = 2**ADDR_W)
DATA_W, 8, instruction width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
enable  input  1  run request; low parks sequencer in IDLE
restart  input  1  single-cycle pulse; pc <= start_addr
start_addr  input  ADDR_W  restart target
wrap_bottom  input  ADDR_W  wrap target
wrap_top  input  ADDR_W  wrap source address
stall  input  1  executor back-pressure
jmp_valid  input  1  executor requests jump
jmp_addr  input  ADDR_W  jump target
instr_out  output  DATA_W  registered instruction to executor
instr_pc  output  ADDR_W  address of instr_out
instr_valid  output  1  instr_out valid this cycle
pc  output  ADDR_W  current fetch address
rf_read_addr  output  ADDR_W  regfile read address (combinational = pc)
rf_data_out  input  DATA_W  regfile combinational read data
load_valid  input  1  host write request
load_ready  output  1  host write grant
load_addr  input  ADDR_W  host write address
load_data  input  DATA_W  host write data
rf_write_en  output  1  regfile write enable
rf_write_addr  output  ADDR_W  regfile write address
rf_data_in  output  DATA_W  regfile write data

Behaviour:
- Reset (async, any state): state=IDLE, pc=0, instr_out=0, instr_pc=0, instr_valid=0.
- States: IDLE, RUN, STALL.
- IDLE -> RUN when enable=1. RUN -> STALL when stall=1. STALL -> RUN when stall=0. RUN/STALL -> IDLE when enable=0; pc held.
- RUN, stall=0: instr_out<=rf_data_out, instr_pc<=pc, instr_valid<=1, pc<=next_pc. Fetch latency is 1 cycle.
- next_pc priority, highest first:
  - jmp_valid: jmp_addr. In that cycle instr_valid<=0 (1-cycle flush bubble; the fetched word is discarded).
  - pc==wrap_top: wrap_bottom.
  - otherwise: pc+1, modulo 2**ADDR_W.
- wrap_top<wrap_bottom is legal; wrap is applied only on reaching wrap_top.
- STALL: pc, instr_out and instr_pc held; instr_valid<=0. jmp_valid is ignored; the executor holds it until the stall clears.
- IDLE: instr_valid<=0, pc held.
- restart=1 (any state): pc<=start_addr, instr_valid<=0. Overrides jump and wrap; state unchanged.
- Host load port:
  - load_ready = (state==IDLE), combinational.
  - rf_write_en = load_valid & load_ready.
  - rf_write_addr=load_addr, rf_data_in=load_data (passthrough).
  - Loads while in RUN/STALL are held off, not dropped.
  - IDLE with enable and load_valid both high: the write occurs in that cycle, then the state goes to RUN.
- Reading an address in the same cycle it is written returns the old data (regfile write is registered).

Optional Feature:
PIO_FETCH_BREAKPOINT_EN.
- Defined: adds inputs bp_en (1) and bp_addr (ADDR_W) and output bp_hit (1, reset 0).
  - In RUN, when bp_en=1 and pc==bp_addr with no jump, the instruction is issued normally.
  - State then goes to IDLE and bp_hit is set; bp_hit is cleared by restart or enable=0.
  - While bp_hit=1, IDLE->RUN is blocked.
- Undefined: ports absent; no breakpoint logic.

Decomposition:
Shared package pio_pkg:
- ADDR_W and DATA_W defaults
- state enum fetch_state_t {IDLE, RUN, STALL}
- function next_pc(pc, wrap_top, wrap_bottom)

Sub-module pio_pc_next (combinational next-pc and priority mux) is natural; the FSM and output registers stay in the top.

Test Plan:
1. Reset asserted mid-RUN at pc=7 -> same cycle: instr_valid=0, pc=0, state IDLE, load_ready=1.
2. bottom=2, top=5, start=2, restart then enable -> instr_pc sequence 2,3,4,5,2,3 with instr_valid=1 each cycle; instr_out matches loaded words.
3. Running at pc=4, jmp_valid with jmp_addr=9 -> next cycle instr_valid=0, pc=9; following cycle instr_pc=9.
4. stall high 3 cycles at pc=3 -> pc stays 3, instr_valid=0 for 3 cycles; jmp_valid during stall ignored; resumes with instr_pc=3.
5. Host loads 0xA5 to addr 6 in IDLE -> rf_write_en=1 that cycle. Same load during RUN -> load_ready=0, rf_write_en=0 until enable drops.
6. restart and jmp_valid in same cycle, start_addr=1, jmp_addr=8 -> pc=1. With PIO_FETCH_BREAKPOINT_EN, bp_addr=3 -> instr_pc=3 issued, then IDLE, bp_hit=1.
